// File: rtl/control_pipeline.sv
// control_pipeline: hazard and sequencing controller for the 5-stage JOF32 pipeline
module control_pipeline #(
  parameter int ANCHO_DIR    = 4,
  parameter int CICLOS_FLUSH = 2,
  parameter int ANCHO_CNT    = 16,
  parameter int MAX_ESPERA   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ANCHO_DIR-1:0] id_rs1,
  input  logic [ANCHO_DIR-1:0] id_rs2,
  input  logic                 id_usa_rs1,
  input  logic                 id_usa_rs2,
  input  logic [ANCHO_DIR-1:0] ex_dir_wb,
  input  logic                 ex_reg_wr,
  input  logic                 ex_sel_ld,
  input  logic                 salto_tomado,
  input  logic                 mem_req,
  input  logic                 mem_listo,
  output logic                 pc_wr,
  output logic                 if_id_wr,
  output logic                 if_id_flush,
  output logic                 id_ex_burbuja,
  output logic                 ex_mem_wr,
  output logic                 mem_wb_burbuja,
  output logic [ANCHO_CNT-1:0] cnt_stall,
  output logic                 err_mem
);
  localparam logic [1:0] NORMAL = 2'd0, FLUSH = 2'd1, ESPERA_MEM = 2'd2;
  localparam int FW = $clog2(CICLOS_FLUSH + 1);
  localparam int WW = $clog2(MAX_ESPERA + 1);
  logic [1:0] r_state, w_nstate;
  logic [FW-1:0] r_fcnt, w_nf;
  logic [WW-1:0] r_wcnt, w_nw;
  logic [ANCHO_CNT-1:0] r_cnt;
  logic r_err;
  logic w_mw, w_lu, w_fl, w_lus, w_to;
  assign w_mw = mem_req & ~mem_listo;
  assign w_lu = ex_sel_ld & ex_reg_wr & (ex_dir_wb != '0) &
                ((id_usa_rs1 & (id_rs1 == ex_dir_wb)) | (id_usa_rs2 & (id_rs2 == ex_dir_wb)));
  assign w_fl = ~w_mw & ((r_state == FLUSH) | ((r_state == NORMAL) & salto_tomado));
  assign w_lus = ~w_mw & (r_state == NORMAL) & ~salto_tomado & w_lu;
  assign w_to = (r_state == ESPERA_MEM) & w_mw & (r_wcnt == WW'(MAX_ESPERA - 1));
  assign pc_wr = ~rst & ~w_mw & ~w_lus;
  assign if_id_wr = ~rst & ~w_mw & ~w_lus;
  assign if_id_flush = rst | w_fl;
  assign id_ex_burbuja = rst | w_fl | w_lus;
  assign ex_mem_wr = ~rst & ~w_mw;
  assign mem_wb_burbuja = rst | w_mw;
  assign cnt_stall = r_cnt;
  assign err_mem = r_err;
  // A branch that coincides with a wait is remembered as a full flush replayed after the wait
  always_comb begin
    w_nstate = r_state;
    w_nf = r_fcnt;
    w_nw = r_wcnt;
    if (r_state == ESPERA_MEM) begin
      if (!w_mw) w_nstate = (r_fcnt != '0) ? FLUSH : NORMAL;
      else if (w_to) begin
        w_nstate = NORMAL;
        w_nf = '0;
      end else w_nw = r_wcnt + WW'(1);
    end else if (w_mw) begin
      w_nstate = ESPERA_MEM;
      w_nw = WW'(1);
      w_nf = (r_state == FLUSH) ? r_fcnt - FW'(1) : (salto_tomado ? FW'(CICLOS_FLUSH) : '0);
    end else if (r_state == FLUSH) begin
      w_nf = r_fcnt - FW'(1);
      w_nstate = (r_fcnt == FW'(1)) ? NORMAL : FLUSH;
    end else if (salto_tomado && CICLOS_FLUSH > 1) begin
      w_nstate = FLUSH;
      w_nf = FW'(CICLOS_FLUSH - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= NORMAL;
      r_fcnt <= '0;
      r_wcnt <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_fcnt <= w_nf;
      r_wcnt <= w_nw;
      r_err <= r_err | w_to;
      if (!pc_wr && r_cnt != '1) r_cnt <= r_cnt + ANCHO_CNT'(1);
    end
  end
endmodule
